// File: rtl/ahb_fifo_read_ser.sv
// rtl/ahb_fifo_read_ser.sv - JTAG DR serializer draining a FWFT read FIFO into framed TDO bits
//
// Purpose: while the data register is selected and the TAP is in Shift-DR,
// streams fixed-length frames out of TDO, LSB first. A data frame carries
// one popped FIFO word; an all-zero idle frame is sent when nothing is queued.
//
// Data frame layout (bit 0 first on TDO):
//   start=1, rdata[0] .. rdata[DATA_WIDTH-1], [even parity], stop=0
// Idle frame: all zeros (a 0 start bit tells the host "no data").
//
// Build option: define AHB_FIFO_READ_PARITY_EN to insert the parity bit
// (XOR of rdata) before the stop bit; the frame then grows by one bit.
//
// Ports:
//   TCK                  in   sole clock, all state moves on posedge
//   tlr_reset            in   synchronous active-high reset (Test-Logic-Reset)
//   dr_shift             in   TAP is in Shift-DR
//   ahb_fifo_read_select in   this DR is selected by the IR
//   empty                in   read FIFO empty (first-word-fall-through)
//   rdata                in   FIFO head word, valid while empty=0
//   rinc                 out  one-cycle FIFO pop strobe
//   TDO                  out  serial frame bit (shift-register LSB)
//   frames_sent          out  count of completed data frames (wraps)

module ahb_fifo_read_ser #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  TCK,
    input  logic                  tlr_reset,
    input  logic                  dr_shift,
    input  logic                  ahb_fifo_read_select,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rinc,
    output logic                  TDO,
    output logic [CNT_WIDTH-1:0]  frames_sent
);

`ifdef AHB_FIFO_READ_PARITY_EN
    localparam int FL = DATA_WIDTH + 3;
`else
    localparam int FL = DATA_WIDTH + 2;
`endif
    localparam int            CW       = $clog2(FL);
    localparam logic [CW-1:0] LAST_BIT = CW'(FL - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_FILL = 2'd2
    } state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [FL-1:0]          r_sr;
    logic [CNT_WIDTH-1:0]   r_frames;

    logic                   w_shift;
    logic                   w_last;
    logic                   w_load;
    logic [FL-1:0]          w_frame;

    assign w_shift = dr_shift & ahb_fifo_read_select;

    // The counter is held at 0 in IDLE, so only an active frame can hit its last bit.
    assign w_last  = w_shift && (r_state != S_IDLE) && (r_cnt == LAST_BIT);

    // A data frame is captured from rdata either while parked in IDLE (only when
    // not shifting: a shift request starts an idle frame instead) or on the last
    // bit of any frame.
    assign w_load  = !tlr_reset && !empty &&
                     (((r_state == S_IDLE) && !w_shift) || w_last);

    // The pop strobe coincides with the edge that captures rdata, so the FIFO
    // advances exactly when its head word has been taken.
    assign rinc        = w_load;
    assign TDO         = r_sr[0];
    assign frames_sent = r_frames;

    always_comb begin
        w_frame               = '0;
        w_frame[0]            = 1'b1;
        w_frame[DATA_WIDTH:1] = rdata;
`ifdef AHB_FIFO_READ_PARITY_EN
        w_frame[DATA_WIDTH+1] = ^rdata;
`endif
    end

    always_ff @(posedge TCK) begin
        if (tlr_reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_sr     <= '0;
            r_frames <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_shift) begin
                        // Host is already clocking: send an idle frame.
                        r_sr    <= {1'b0, r_sr[FL-1:1]};
                        r_cnt   <= r_cnt + 1'b1;
                        r_state <= S_FILL;
                    end else if (w_load) begin
                        r_sr    <= w_frame;
                        r_state <= S_DATA;
                    end
                end
                default: begin
                    // shift=0 (e.g. Pause-DR) holds everything mid-frame.
                    if (w_shift) begin
                        if (w_last) begin
                            if (r_state == S_DATA) begin
                                r_frames <= r_frames + 1'b1;
                            end
                            r_cnt <= '0;
                            if (w_load) begin
                                r_sr    <= w_frame;
                                r_state <= S_DATA;
                            end else begin
                                r_sr    <= '0;
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_sr  <= {1'b0, r_sr[FL-1:1]};
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
